// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter: owner tag encoding,
// access size encoding, arbiter state encoding and the request attribute
// bundle that travels with a captured request.
package mem_req_arbiter_pkg;

  // Owner tag stored per accepted request
  localparam logic TAG_INST = 1'b0;
  localparam logic TAG_DATA = 1'b1;

  // Access size encoding on data_size / mem_size
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_D = 2'd1,
    ST_GRANT_I = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    logic [3:0] wstrb;
  } req_attr_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of the three handshake groups around the arbiter:
//   inst_*  : IF-stage read requester
//   data_*  : EXE/MEM load/store requester
//   mem_*   : shared SRAM-like port
// Modports:
//   slave  : the arbiter's view (requests and port responses are inputs)
//   master : the environment's view (requesters plus memory)
interface mem_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/mem_req_arbiter_tag_fifo.sv
// In-order owner tag queue: 1 bit wide, DEPTH deep, read/write pointers
// with explicit wrap so any DEPTH in 1..4 works.
// Ports:
//   clk, rst   : clock, async active-high reset
//   push_i     : enqueue tag_i (dropped if full and not popping)
//   tag_i      : owner tag to enqueue
//   pop_i      : dequeue head (ignored when empty)
//   head_o     : tag at queue head
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   cnt_o      : current occupancy
module arb_tag_fifo #(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          tag_i,
  input  logic          pop_i,
  output logic          head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] cnt_o
);
  logic [DEPTH-1:0] tags_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign head_o  = tags_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        tags_q[wr_ptr_q] <= tag_i;
        wr_ptr_q         <= wrap_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= wrap_inc(rd_ptr_q);
      if (do_push & ~do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop & ~do_push) cnt_q <= cnt_q - CW'(1);
    end
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access.
// Data wins over inst; a granted request is captured and held on mem_*
// until mem_addr_ok. Every accepted request's owner goes into an in-order
// tag queue, which steers each returning mem_data_ok to inst or data.
// Ports:
//   clk, reset : clock, async active-high reset
//   bus        : slave modport carrying inst_*, data_* and mem_* groups
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input logic               clk,
  input logic               reset,
  mem_req_arbiter_if.slave  bus
);
  localparam int CW = $clog2(OUTSTANDING + 1);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  req_attr_t         attr_q, attr_d;

  logic          accept, pop_eff, rearb, d_cand, i_cand, full_nx;
  logic          head, full, empty;
  logic [CW-1:0] cnt;

  assign accept  = (state_q != ST_IDLE) & bus.mem_addr_ok;
  // A response with nothing outstanding is a protocol error and is dropped
  assign pop_eff = bus.mem_data_ok & ~empty;
  assign rearb   = (state_q == ST_IDLE) | bus.mem_addr_ok;

  // Occupancy after this edge, so a slot freed this cycle can be granted
  // next cycle and the slot filled this cycle blocks a new grant.
  assign full_nx = (full & (~pop_eff | accept)) |
                   ((cnt == CW'(OUTSTANDING - 1)) & accept & ~pop_eff);

  // In the accept cycle the winner's req still belongs to the request just
  // taken, so it is masked out of re-arbitration to avoid a double issue.
  assign d_cand = bus.data_req & ~((state_q == ST_GRANT_D) & bus.mem_addr_ok);
  assign i_cand = bus.inst_req & ~((state_q == ST_GRANT_I) & bus.mem_addr_ok);

  arb_tag_fifo #(.DEPTH(OUTSTANDING)) u_tags (
    .clk     (clk),
    .rst     (reset),
    .push_i  (accept),
    .tag_i   ((state_q == ST_GRANT_D) ? TAG_DATA : TAG_INST),
    .pop_i   (pop_eff),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .cnt_o   (cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      attr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      attr_q  <= attr_d;
    end
  end

  // Next state and captured request fields
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    attr_d  = attr_q;
    if (rearb) begin
      if (full_nx) begin
        state_d = ST_IDLE;
      end else if (d_cand) begin
        state_d = ST_GRANT_D;
        addr_d  = bus.data_addr;
        wdata_d = bus.data_wdata;
        attr_d  = '{wr: bus.data_wr, size: bus.data_size, wstrb: bus.data_wstrb};
      end else if (i_cand) begin
        state_d = ST_GRANT_I;
        addr_d  = bus.inst_addr;
        wdata_d = '0;
        attr_d  = '{wr: 1'b0, size: SIZE_WORD, wstrb: 4'h0};
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    bus.mem_req      = (state_q != ST_IDLE);
    bus.mem_addr     = addr_q;
    bus.mem_wdata    = wdata_q;
    bus.mem_wr       = attr_q.wr;
    bus.mem_size     = attr_q.size;
    bus.mem_wstrb    = attr_q.wstrb;
    bus.inst_addr_ok = (state_q == ST_GRANT_I) & bus.mem_addr_ok;
    bus.data_addr_ok = (state_q == ST_GRANT_D) & bus.mem_addr_ok;
    bus.inst_data_ok = pop_eff & (head == TAG_INST);
    bus.data_data_ok = pop_eff & (head == TAG_DATA);
    bus.inst_rdata   = bus.mem_rdata;
    bus.data_rdata   = bus.mem_rdata;
  end

`ifdef MEM_REQ_ARB_CHECKS
  always_ff @(posedge clk) begin
    if (!reset) assert (!(bus.mem_data_ok && empty))
      else $error("mem_data_ok with no outstanding request");
  end
`endif
endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;
  localparam int OUT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_req_arbiter #(.OUTSTANDING(OUT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: current grant (0 none, 1 inst, 2 data), the fields it
  // presents, and the ordered list of owners still awaiting a response.
  int          mg;
  logic [31:0] m_addr, m_wdata;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  bit          q[$];
  bit          p_iaok, p_daok;

  task automatic chk1(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic idle_in();
    bus.inst_req = 0; bus.inst_addr = '0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0; bus.data_wstrb = 0;
    bus.data_addr = '0; bus.data_wdata = '0;
    bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = '0;
  endtask

  task automatic model_reset();
    mg = 0; q.delete(); p_iaok = 0; p_daok = 0;
  endtask

  task automatic set_data(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    bus.data_req = 1; bus.data_wr = wr; bus.data_size = 2'd2;
    bus.data_wstrb = wr ? 4'hF : 4'h0; bus.data_addr = addr; bus.data_wdata = wd;
  endtask

  // Called at a negedge with inputs driven: check outputs, then advance the
  // model across the coming rising edge.
  task automatic cyc();
    bit pop;
    bit dcand, icand;
    #1;
    p_iaok = (mg == 1) && bus.mem_addr_ok;
    p_daok = (mg == 2) && bus.mem_addr_ok;
    pop    = bus.mem_data_ok && (q.size() > 0);
    chk1("mem_req", bus.mem_req, mg != 0);
    if (mg != 0) begin
      chk32("mem_addr", bus.mem_addr, m_addr);
      chk1("mem_wr", bus.mem_wr, m_wr);
      chk32("mem_size", 32'(bus.mem_size), 32'(m_size));
      chk32("mem_wstrb", 32'(bus.mem_wstrb), 32'(m_wstrb));
      if (mg == 2) chk32("mem_wdata", bus.mem_wdata, m_wdata);
    end
    chk1("inst_addr_ok", bus.inst_addr_ok, p_iaok);
    chk1("data_addr_ok", bus.data_addr_ok, p_daok);
    chk1("inst_data_ok", bus.inst_data_ok, pop && (q[0] == 1'b0));
    chk1("data_data_ok", bus.data_data_ok, pop && (q[0] == 1'b1));
    chk32("inst_rdata", bus.inst_rdata, bus.mem_rdata);
    chk32("data_rdata", bus.data_rdata, bus.mem_rdata);
    if (pop) void'(q.pop_front());
    if (p_iaok || p_daok) q.push_back(p_daok);
    if (mg == 0 || p_iaok || p_daok) begin
      dcand = bus.data_req && !p_daok;
      icand = bus.inst_req && !p_iaok;
      if (q.size() >= OUT) mg = 0;
      else if (dcand) begin
        mg = 2; m_addr = bus.data_addr; m_wdata = bus.data_wdata;
        m_wr = bus.data_wr; m_size = bus.data_size; m_wstrb = bus.data_wstrb;
      end else if (icand) begin
        mg = 1; m_addr = bus.inst_addr; m_wr = 0; m_size = 2'd2; m_wstrb = 4'h0;
      end else mg = 0;
    end
    @(negedge clk);
  endtask

  task automatic chk_all_low(input string tag);
    chk1({tag, "_mem_req"}, bus.mem_req, 1'b0);
    chk1({tag, "_iaok"}, bus.inst_addr_ok, 1'b0);
    chk1({tag, "_daok"}, bus.data_addr_ok, 1'b0);
    chk1({tag, "_idok"}, bus.inst_data_ok, 1'b0);
    chk1({tag, "_ddok"}, bus.data_data_ok, 1'b0);
  endtask

  initial begin
    idle_in(); model_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    bus.mem_addr_ok = 1; bus.mem_data_ok = 1; bus.data_req = 1;
    #1 chk_all_low("reset");
    idle_in(); reset = 0;
    @(negedge clk);

    // Single load, response DEADBEEF
    set_data(0, 32'h1000, 32'h0);           cyc();
    bus.mem_addr_ok = 1;
    #1 chk1("t1_daok", bus.data_addr_ok, 1'b1); cyc();
    idle_in();                              cyc();
    bus.mem_data_ok = 1; bus.mem_rdata = 32'hDEADBEEF;
    #1 chk1("t1_ddok", bus.data_data_ok, 1'b1);
    chk32("t1_rdata", bus.data_rdata, 32'hDEADBEEF);
    chk1("t1_idok", bus.inst_data_ok, 1'b0); cyc();
    idle_in();                              cyc();

    // Simultaneous requests: data first, inst right after
    bus.inst_req = 1; bus.inst_addr = 32'h2000;
    set_data(1, 32'h3000, 32'h1234);        cyc();
    bus.mem_addr_ok = 1;
    #1 chk32("t2_first", bus.mem_addr, 32'h3000); cyc();
    bus.data_req = 0;
    #1 chk32("t2_second", bus.mem_addr, 32'h2000); cyc();
    idle_in(); bus.mem_data_ok = 1; bus.mem_rdata = 32'hA5A5;
    #1 chk1("t2_resp_d", bus.data_data_ok, 1'b1); cyc();
    #1 chk1("t2_resp_i", bus.inst_data_ok, 1'b1); cyc();
    idle_in();                              cyc();

    // Lock: inst held while data rises, data granted afterwards
    bus.inst_req = 1; bus.inst_addr = 32'h4000; cyc();
    set_data(0, 32'h5000, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1 chk32("t3_lock", bus.mem_addr, 32'h4000); cyc();
    end
    bus.mem_addr_ok = 1;
    #1 chk1("t3_iaok", bus.inst_addr_ok, 1'b1); cyc();
    bus.inst_req = 0;
    #1 chk32("t3_next", bus.mem_addr, 32'h5000); cyc();
    idle_in(); bus.mem_data_ok = 1;         cyc(); cyc();
    idle_in();                              cyc();

    // Full: two accepted, third held off until a response frees a slot
    bus.mem_addr_ok = 1;
    set_data(0, 32'h6000, 32'h0);           cyc(); cyc();
    bus.data_addr = 32'h6004;               cyc(); cyc();
    bus.data_addr = 32'h6008;
    #1 chk1("t4_full0", bus.mem_req, 1'b0); cyc();
    #1 chk1("t4_full1", bus.mem_req, 1'b0); cyc();
    bus.mem_data_ok = 1;                    cyc();
    bus.mem_data_ok = 0;
    #1 chk1("t4_regrant", bus.mem_req, 1'b1);
    chk32("t4_addr", bus.mem_addr, 32'h6008); cyc();
    idle_in(); bus.mem_data_ok = 1;         cyc(); cyc();
    idle_in();                              cyc();

    // Push and pop in the same cycle
    bus.mem_addr_ok = 1; set_data(0, 32'h7000, 32'h0); cyc(); cyc();
    idle_in(); bus.inst_req = 1; bus.inst_addr = 32'h7100; cyc();
    bus.mem_addr_ok = 1; bus.mem_data_ok = 1;
    #1 chk1("t5_ddok", bus.data_data_ok, 1'b1);
    chk1("t5_iaok", bus.inst_addr_ok, 1'b1); cyc();
    idle_in(); bus.mem_data_ok = 1;
    #1 chk1("t5_idok", bus.inst_data_ok, 1'b1); cyc();
    idle_in();                              cyc();

    // Randomized traffic, exercising pointer wrap many times
    for (int n = 0; n < 600; n++) begin
      if (!bus.inst_req && $urandom_range(0, 2) == 0) begin
        bus.inst_req = 1; bus.inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!bus.data_req && $urandom_range(0, 2) == 0) begin
        bus.data_req = 1; bus.data_wr = 1'($urandom_range(0, 1));
        bus.data_size = 2'($urandom_range(0, 2)); bus.data_wstrb = 4'($urandom);
        bus.data_addr = $urandom; bus.data_wdata = $urandom;
      end
      bus.mem_addr_ok = 1'($urandom_range(0, 1));
      bus.mem_data_ok = ($urandom_range(0, 2) == 0);
      bus.mem_rdata   = $urandom;
      cyc();
      if (p_iaok) bus.inst_req = 0;
      if (p_daok) bus.data_req = 0;
    end
    idle_in(); bus.mem_data_ok = 1; cyc(); cyc(); cyc();
    idle_in(); cyc();

    // Async reset mid-grant with one outstanding
    bus.mem_addr_ok = 1; set_data(0, 32'h8000, 32'h0); cyc(); cyc();
    idle_in(); bus.inst_req = 1; bus.inst_addr = 32'h8100; cyc();
    #2 bus.mem_addr_ok = 1; bus.mem_data_ok = 1; reset = 1;
    #1 chk_all_low("midrst");
    @(negedge clk);
    idle_in(); reset = 0; model_reset();
    bus.mem_data_ok = 1; bus.mem_rdata = 32'h5555;
    #1 chk1("stale_ddok", bus.data_data_ok, 1'b0);
    chk1("stale_idok", bus.inst_data_ok, 1'b0); cyc();
    idle_in(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
